// File: rtl/adder_pkg.sv
// ============================================================================
// adder_pkg : shared constants and helpers for the pipelined lookahead adder
// Rev 1.0
// ============================================================================
`default_nettype none

package adder_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  function automatic int calc_stages(input int n, input int k);
    return n / k;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_group.sv
// ============================================================================
// cla_group : combinational K-bit carry-lookahead group
// Rev 1.0
// ============================================================================
`default_nettype none

module cla_group #(
  parameter int K = 4
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         c_in,
  output logic [K-1:0] s,
  output logic         c_out,
  output logic         c_msb
);

  logic [K-1:0] w_g;
  logic [K-1:0] w_p;
  logic [K:0]   w_c;

  assign w_g = a & b;
  assign w_p = a | b;

  // Each carry is a flat sum of products over the group, not a ripple chain.
  always_comb begin : p_lookahead
    logic w_term;
    logic w_pp;
    w_c    = '0;
    w_c[0] = c_in;
    w_term = 1'b0;
    w_pp   = 1'b1;
    for (int i = 0; i < K; i++) begin
      w_term = 1'b0;
      w_pp   = 1'b1;
      for (int k = i; k >= 0; k--) begin
        w_term = w_term | (w_g[k] & w_pp);
        w_pp   = w_pp & w_p[k];
      end
      w_c[i+1] = w_term | (w_pp & c_in);
    end
  end

  assign s     = a ^ b ^ w_c[K-1:0];
  assign c_out = w_c[K];
  assign c_msb = w_c[K-1];

endmodule

`default_nettype wire

// File: rtl/adder_cl_pipe.sv
// ============================================================================
// adder_cl_pipe : pipelined carry-lookahead adder/subtractor, one group per rank
// Rev 1.0
// ============================================================================
`default_nettype none

module adder_cl_pipe
  import adder_pkg::*;
#(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         co,
  output logic         ovf
);

  localparam int STAGES = calc_stages(N, K);

  generate
    if (N % K != 0) begin : g_bad_group_width
      $error("adder_cl_pipe: N must be a multiple of K");
    end
  endgenerate

  logic [STAGES-1:0]         valid_q, valid_d;
  logic [STAGES-1:0]         carry_q, carry_d;
  logic [STAGES-1:0]         cmsb_q, cmsb_d;
  logic [STAGES-1:0][N-1:0]  sum_q, sum_d;
  logic [STAGES-1:0][N-1:0]  a_q, a_d;
  logic [STAGES-1:0][N-1:0]  b_q, b_d;

  logic [STAGES-1:0][K-1:0]  w_grp_a, w_grp_b, w_grp_s;
  logic [STAGES-1:0]         w_grp_cin, w_grp_co, w_grp_cmsb;
  logic [N-1:0]              w_b_eff;
  logic                      w_c0;
  logic                      w_adv;
  logic                      w_unused_ops;

  assign w_adv    = !valid_q[STAGES-1] || out_ready;
  assign in_ready = w_adv;
  assign w_b_eff  = (sub == SUB) ? ~b : b;
  assign w_c0     = (sub == SUB) ? 1'b1 : ci;

  // Group j reads its operand slice from rank j-1; group 0 reads the ports.
  generate
    for (genvar j = 0; j < STAGES; j++) begin : g_rank
      if (j == 0) begin : g_first
        assign w_grp_a[j]   = a[K-1:0];
        assign w_grp_b[j]   = w_b_eff[K-1:0];
        assign w_grp_cin[j] = w_c0;
      end else begin : g_next
        assign w_grp_a[j]   = a_q[j-1][j*K +: K];
        assign w_grp_b[j]   = b_q[j-1][j*K +: K];
        assign w_grp_cin[j] = carry_q[j-1];
      end

      cla_group #(.K(K)) u_grp (
        .a     (w_grp_a[j]),
        .b     (w_grp_b[j]),
        .c_in  (w_grp_cin[j]),
        .s     (w_grp_s[j]),
        .c_out (w_grp_co[j]),
        .c_msb (w_grp_cmsb[j])
      );
    end
  endgenerate

  always_comb begin
    valid_d     = '0;
    carry_d     = '0;
    cmsb_d      = '0;
    sum_d       = '0;
    a_d         = '0;
    b_d         = '0;
    valid_d[0]  = in_valid && w_adv;
    a_d[0]      = a;
    b_d[0]      = w_b_eff;
    sum_d[0][K-1:0] = w_grp_s[0];
    carry_d[0]  = w_grp_co[0];
    for (int j = 1; j < STAGES; j++) begin
      valid_d[j]          = valid_q[j-1];
      a_d[j]              = a_q[j-1];
      b_d[j]              = b_q[j-1];
      sum_d[j]            = sum_q[j-1];
      sum_d[j][j*K +: K]  = w_grp_s[j];
      carry_d[j]          = w_grp_co[j];
    end
    cmsb_d[STAGES-1] = w_grp_cmsb[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      cmsb_q  <= '0;
      sum_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else if (w_adv) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign s         = sum_q[STAGES-1];
  assign co        = carry_q[STAGES-1];
  assign ovf       = cmsb_q[STAGES-1] ^ carry_q[STAGES-1];

  // Already-consumed operand slices and early-rank top-bit carries are dead.
  assign w_unused_ops = ^{a_q, b_q, cmsb_q, w_grp_cmsb};

endmodule

`default_nettype wire

// File: tb/tb_adder_cl_pipe.sv
// ============================================================================
// tb_adder_cl_pipe : scoreboard bench for adder_cl_pipe (K=4 and K=N instances)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_adder_cl_pipe;

  localparam int N      = 16;
  localparam int K      = 4;
  localparam int STAGES = N / K;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0] a, b, s;
  logic         ci, sub, co, ovf;

  logic         in_valid16, in_ready16, out_valid16, out_ready16;
  logic [N-1:0] a16, b16, s16;
  logic         ci16, sub16, co16, ovf16;

  always #5 clk = ~clk;

  adder_cl_pipe #(.N(N), .K(K)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .co(co), .ovf(ovf)
  );

  adder_cl_pipe #(.N(N), .K(N)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .ci(ci16), .sub(sub16), .out_valid(out_valid16),
    .out_ready(out_ready16), .s(s16), .co(co16), .ovf(ovf16)
  );

  typedef struct packed {
    logic [N-1:0] s;
    logic         co;
    logic         ovf;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;

  // Reference: plain wide integer add, overflow from operand/result signs.
  function automatic res_t model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                 input logic mci, input logic msub);
    logic [N:0]   full;
    logic [N-1:0] be;
    logic         c;
    res_t         r;
    be    = msub ? ~mb : mb;
    c     = msub ? 1'b1 : mci;
    full  = {1'b0, ma} + {1'b0, be} + {{N{1'b0}}, c};
    r.s   = full[N-1:0];
    r.co  = full[N];
    r.ovf = (ma[N-1] == be[N-1]) && (r.s[N-1] != ma[N-1]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : p_monitor
    res_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_s", 32'(s), 32'(e.s));
          chk("sb_co", 32'(co), 32'(e.co));
          chk("sb_ovf", 32'(ovf), 32'(e.ovf));
          n_out++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, ci, sub));
    end
  end

  task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb,
                      input logic tci, input logic tsub);
    int   guard;
    logic acc;
    guard    = 0;
    acc      = 1'b0;
    in_valid = 1'b1;
    a = ta; b = tb; ci = tci; sub = tsub;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 50);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic directed(input string name, input logic [N-1:0] ta, input logic [N-1:0] tb,
                          input logic tci, input logic tsub,
                          input logic [N-1:0] es, input logic eco, input logic eovf);
    int cnt;
    send(ta, tb, tci, tsub);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!out_valid && cnt < 20);
    chk({name, "_latency"}, 32'(cnt), 32'(STAGES));
    chk({name, "_s"}, 32'(s), 32'(es));
    chk({name, "_co"}, 32'(co), 32'(eco));
    chk({name, "_ovf"}, 32'(ovf), 32'(eovf));
    @(posedge clk);
    #1;
  endtask

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : p_stim
    logic [N-1:0] held;
    int           n0;
    int           cnt;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; ci16 = 1'b0; sub16 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_co", 32'(co), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed("wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("sub_lt", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("sub_gt", 16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    directed("povf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("novf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Single-rank instance: result visible right after the accepting edge.
    a16 = 16'hFFFF; b16 = 16'h0001; in_valid16 = 1'b1;
    @(negedge clk);
    chk("k16_in_ready", 32'(in_ready16), 32'd1);
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    @(negedge clk);
    chk("k16_out_valid", 32'(out_valid16), 32'd1);
    chk("k16_s", 32'(s16), 32'h0000);
    chk("k16_co", 32'(co16), 32'd1);
    chk("k16_ovf", 32'(ovf16), 32'd0);
    @(posedge clk);
    #1;

    fork
      begin
        for (int i = 0; i < 8; i++) send(16'(i), 16'(i * 32'h1111), 1'b0, 1'b0);
      end
      begin
        cnt = 0;
        do begin
          @(negedge clk);
          cnt++;
        end while (!out_valid && cnt < 20);
        chk("b2b_latency", 32'(cnt), 32'(STAGES + 1));
        for (int k = 1; k < 8; k++) begin
          @(negedge clk);
          chk("b2b_run", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        chk("b2b_end", 32'(out_valid), 32'd0);
      end
    join
    @(posedge clk);
    #1;

    out_ready = 1'b0;
    n0 = n_out;
    for (int i = 0; i < 4; i++) send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    chk("stall_full", 32'(out_valid), 32'd1);
    held = s;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_s_hold", 32'(s), 32'(held));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("stall_delivered", 32'(n_out - n0), 32'd4);
    chk("stall_queue_empty", 32'(exp_q.size()), 32'd0);

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'(16'h1234 + i), 16'h0101, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_s", 32'(s), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_idle", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 400; i++) begin
      a         = 16'($urandom);
      b         = 16'($urandom);
      ci        = 1'($urandom);
      sub       = 1'($urandom);
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (STAGES + 4) @(posedge clk);
    #1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
